// File: rtl/fft_pkg.sv
// Shared constants, lane offsets and types for the 16-point FFT result unloader.
package fft_pkg;

  localparam int unsigned POINT_W      = 17;
  localparam int unsigned PTS_PER_WORD = 4;
  localparam int unsigned WORDS        = 4;
  localparam int unsigned FRAME_PTS    = PTS_PER_WORD * WORDS;
  localparam int unsigned LANE_W       = 2 * POINT_W;
  localparam int unsigned WORD_W       = LANE_W * PTS_PER_WORD;
  localparam int unsigned IDX_W        = $clog2(FRAME_PTS);
  localparam int unsigned WC_W         = $clog2(WORDS);

  // MSB position of Re / Im for lane j; lane 0 sits at the top of the word.
  localparam int unsigned RE_OFS [PTS_PER_WORD] = '{135, 101, 67, 33};
  localparam int unsigned IM_OFS [PTS_PER_WORD] = '{118, 84, 50, 16};

  typedef struct packed {
    logic [POINT_W-1:0] re;
    logic [POINT_W-1:0] im;
  } cpoint_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/fft_frame_buffer.sv
// 16-entry complex-point register file: 4-lane word write, single-point read.
module fft_frame_buffer
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [WC_W-1:0]   wr_word,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_addr,
  output cpoint_t           rd_data
);

  cpoint_t mem_q [FRAME_PTS];

  // Lane j of word wc carries frequency bin wc + 4j.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FRAME_PTS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      for (int j = 0; j < PTS_PER_WORD; j++) begin
        mem_q[IDX_W'(j * WORDS) + IDX_W'(wr_word)].re <= wr_data[RE_OFS[j] -: POINT_W];
        mem_q[IDX_W'(j * WORDS) + IDX_W'(wr_word)].im <= wr_data[IM_OFS[j] -: POINT_W];
      end
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fft_result_unloader.sv
// Buffers four stage-2 FFT result words, then streams X[0]..X[15] in natural order.
module fft_result_unloader
  import fft_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_word,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [POINT_W-1:0] out_re,
  output logic [POINT_W-1:0] out_im,
  output logic [IDX_W-1:0]   out_index,
  output logic               out_last,
  output logic               frame_done
);

  state_t           state_q;
  logic [WC_W-1:0]  wc_q;
  logic [IDX_W-1:0] n_q;
  logic             frame_done_q;
  logic             in_hs;
  logic             out_hs;
  cpoint_t          rd_point;

  assign in_hs  = (state_q == FILL) && in_valid;
  assign out_hs = (state_q == DRAIN) && out_ready;

  // clear takes priority over any handshake in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      wc_q         <= '0;
      n_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (clear) begin
        state_q <= FILL;
        wc_q    <= '0;
        n_q     <= '0;
      end else begin
        unique case (state_q)
          FILL: begin
            if (in_hs) begin
              wc_q <= wc_q + WC_W'(1);
              if (wc_q == WC_W'(WORDS - 1)) begin
                state_q <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (out_hs) begin
              n_q <= n_q + IDX_W'(1);
              if (n_q == IDX_W'(FRAME_PTS - 1)) begin
                state_q      <= FILL;
                frame_done_q <= 1'b1;
              end
            end
          end
          default: state_q <= FILL;
        endcase
      end
    end
  end

  fft_frame_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .we      (in_hs && !clear),
    .wr_word (wc_q),
    .wr_data (in_word),
    .rd_addr (n_q),
    .rd_data (rd_point)
  );

  assign in_ready   = (state_q == FILL);
  assign out_valid  = (state_q == DRAIN);
  assign out_re     = rd_point.re;
  assign out_im     = rd_point.im;
  assign out_index  = n_q;
  assign out_last   = (state_q == DRAIN) && (n_q == IDX_W'(FRAME_PTS - 1));
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_result_unloader.sv
// Directed, table-driven bench for fft_result_unloader.
module tb_fft_result_unloader;

  logic         clk;
  logic         rst;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [135:0] in_word;
  logic         out_valid;
  logic         out_ready;
  logic [16:0]  out_re;
  logic [16:0]  out_im;
  logic [3:0]   out_index;
  logic         out_last;
  logic         frame_done;

  fft_result_unloader dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_index  (out_index),
    .out_last   (out_last),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  typedef struct {
    logic [16:0] re;
    logic [16:0] im;
    logic [3:0]  idx;
    logic        last;
  } vec_t;

  vec_t tbl [2][16];
  int   errors = 0;
  int   checks = 0;
  int   done_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] re_of(input int kind, input int n);
    logic [16:0] t;
    t = 17'(n) << 8;
    return (kind == 0) ? t : 17'h1FF00;
  endfunction

  function automatic logic [16:0] im_of(input int kind, input int n);
    logic [16:0] t;
    t = 17'(n) << 8;
    return (kind == 0) ? (~t + 17'd1) : 17'h00080;
  endfunction

  function automatic logic [135:0] make_word(input int kind, input int w);
    logic [135:0] v;
    v = '0;
    for (int j = 0; j < 4; j++) begin
      v[135 - 34*j -: 17] = re_of(kind, w + 4*j);
      v[118 - 34*j -: 17] = im_of(kind, w + 4*j);
    end
    return v;
  endfunction

  task automatic fill(input int kind, input int nwords);
    for (int w = 0; w < nwords; w++) begin
      in_word  = make_word(kind, w);
      in_valid = 1'b1;
      chk("fill_in_ready", 32'(in_ready), 32'd1);
      chk("fill_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("fill_frame_done", 32'(frame_done), 32'd0);
    end
    in_valid = 1'b0;
  endtask

  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0 repeating.
  task automatic drain(input int kind, input int mode, input bit hold, input logic [135:0] hw);
    int k;
    int cyc;
    k   = 0;
    cyc = 0;
    in_valid = hold;
    if (hold) in_word = hw;
    while (k < 16 && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("drain_in_ready", 32'(in_ready), 32'd0);
      chk("out_index", 32'(out_index), 32'(tbl[kind][k].idx));
      chk("out_re", 32'(out_re), 32'(tbl[kind][k].re));
      chk("out_im", 32'(out_im), 32'(tbl[kind][k].im));
      chk("out_last", 32'(out_last), 32'(tbl[kind][k].last));
      chk("drain_frame_done", 32'(frame_done), 32'd0);
      @(posedge clk); #1;
      if (out_ready) k++;
      cyc++;
    end
    chk("drain_count", 32'(k), 32'd16);
    if (mode == 0) chk("drain_cycles", 32'(cyc), 32'd16);
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    done_cyc  = tcyc;
    out_ready = 1'b0;
  endtask

  initial begin
    int t1;
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 16; n++) begin
        tbl[k][n].re   = re_of(k, n);
        tbl[k][n].im   = im_of(k, n);
        tbl[k][n].idx  = 4'(n);
        tbl[k][n].last = (n == 15);
      end
    end

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_word = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_re", 32'(out_re), 32'd0);
    chk("rst_out_im", 32'(out_im), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic frame
    fill(0, 4);
    drain(0, 0, 1'b0, '0);

    // Backpressure
    fill(0, 4);
    drain(0, 1, 1'b0, '0);

    // Input offered throughout drain becomes word 0 of the next frame
    fill(0, 4);
    drain(0, 0, 1'b1, make_word(0, 0));
    fill(0, 4);
    drain(0, 0, 1'b0, '0);

    // Async reset mid-fill
    fill(0, 2);
    #2 rst = 1'b1;
    #1;
    chk("rstfill_out_valid", 32'(out_valid), 32'd0);
    chk("rstfill_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    fill(0, 4);
    drain(0, 0, 1'b0, '0);

    // Async reset mid-drain drops output at once and clears the buffer
    fill(0, 4);
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rstdrain_index_before", 32'(out_index), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("rstdrain_out_valid", 32'(out_valid), 32'd0);
    chk("rstdrain_in_ready", 32'(in_ready), 32'd1);
    chk("rstdrain_out_index", 32'(out_index), 32'd0);
    chk("rstdrain_out_re", 32'(out_re), 32'd0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // clear mid-drain at index 7
    fill(0, 4);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && out_index != 4'd7; c++) begin
      @(posedge clk); #1;
    end
    chk("clr_at_index", 32'(out_index), 32'd7);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    out_ready = 1'b0;
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd1);
    chk("clr_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk); #1;
    chk("clr_frame_done2", 32'(frame_done), 32'd0);
    fill(0, 4);
    drain(0, 0, 1'b0, '0);

    // clear beats a simultaneous input handshake and rewinds the word count
    fill(0, 2);
    in_word  = make_word(1, 2);
    in_valid = 1'b1;
    clear    = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    fill(0, 4);
    drain(0, 0, 1'b0, '0);

    // Back-to-back frames with in_valid held high
    fill(0, 4);
    drain(0, 0, 1'b1, make_word(1, 0));
    t1 = done_cyc;
    fill(1, 4);
    drain(1, 0, 1'b0, '0);
    chk("frame_period", 32'(done_cyc - t1), 32'd20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_result_unloader.md
Name: fft_result_unloader

Overview:
- Consumer at the output end of the butterfly datapath.
- Accepts the four 136-bit stage-2 result words of a 16-point FFT frame. Word w carries X[w], X[w+4], X[w+8], X[w+12].
- Buffers the full frame, then streams X[0]..X[15] one complex point per cycle in natural order with a valid/ready handshake.
- Sits between the butterfly output register and the downstream output interface and post-processing.

Parameters:
- POINT_W, 17: bits per real or imaginary part; 2's complement, sign + 8 integer + 8 fraction.
- PTS_PER_WORD, 4: complex points per input word.
- WORDS, 4: input words per frame. Frame size is PTS_PER_WORD*WORDS = 16.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- clear, input, 1: synchronous abort; discards the frame in progress.
- in_valid, input, 1: in_word is valid.
- in_ready, output, 1: block can accept in_word.
- in_word, input, 136: 4 complex points. Point j: Re = [135-34j -: 17], Im = [118-34j -: 17]. Point 0 is at the MSB end.
- out_valid, output, 1: out_re / out_im / out_index are valid.
- out_ready, input, 1: downstream accepts the current point.
- out_re, output, 17: real part of X[out_index].
- out_im, output, 17: imaginary part of X[out_index].
- out_index, output, 4: frequency index n, 0..15.
- out_last, output, 1: high with out_valid when n = 15.
- frame_done, output, 1: one-cycle pulse after X[15] is accepted.

Behaviour:
- Reset (rst high, async): state = FILL, word count = 0, point count = 0, buffer cleared to 0. Outputs: in_ready = 1, out_valid = 0, out_re / out_im = 0, out_index = 0, out_last = 0, frame_done = 0.
- Reset mid-frame drops all buffered data with no partial output.
- States: FILL and DRAIN only.
- FILL:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready, store point j of the word as X[wc + 4j] (wc = word count), then wc++.
  - On the 4th accepted word (wc = 3), the next state is DRAIN and wc wraps to 0.
- DRAIN:
  - in_ready = 0. Input words offered here are not consumed, and no overrun is possible.
  - out_valid = 1, driving X[n] from the buffer with n = point count.
  - On out_valid & out_ready, n++.
  - When n = 15 is accepted: n wraps to 0, frame_done = 1 for one cycle, next state is FILL.
- Latency:
  - out_valid rises on the cycle after the 4th word handshake.
  - A frame drains in 16 cycles when out_ready is held high.
  - Minimum frame period is 20 cycles: 4 fill + 16 drain.
- Backpressure: while out_valid & !out_ready, out_re, out_im, out_index and out_last hold stable.
- clear:
  - Returns to FILL with wc = 0 and n = 0; frame_done is not pulsed.
  - clear beats a simultaneous in_valid handshake or out_ready handshake; that word or point is lost.
  - clear in FILL with wc = 0 has no effect.
- No arithmetic; data bits pass unchanged. The sign bit is preserved with no extension or rounding.
- Outputs are driven from registers and a 16:1 mux on the registered n. There is no combinational path from in_* to out_*.
- Word order is implicit: the k-th accepted word after reset, clear or frame end is word k.

Decomposition:
- Shared package fft_pkg holds:
  - POINT_W, PTS_PER_WORD, WORDS and FRAME_PTS = 16.
  - The lane-extract localparams: the Re/Im offsets 135-34j and 118-34j.
  - A complex-point typedef {re, im}, each POINT_W wide.
  - State encodings FILL = 1'b0, DRAIN = 1'b1.
- One natural sub-module: fft_frame_buffer, a 16-entry × 34-bit register file. It has a 4-lane write port (write address wc + 4j) and a 1-lane read port (address n).
- The FSM and counters stay in fft_result_unloader.

Test Plan:
- Basic frame:
  - Stimulus: word w, point j with Re = (w+4j)<<8 and Im = -((w+4j)<<8), i.e. the 17-bit 2's complement. out_ready held at 1.
  - Required: 16 consecutive outputs with out_index = n, out_re = n<<8 (n=1 gives 17'h00100), out_im = 2's complement of out_re. out_last and frame_done behave as specified.
- Backpressure:
  - Stimulus: same frame, out_ready toggling 1,0,0,1,...
  - Required: every index appears exactly once, in order. Data holds while stalled. frame_done comes after 16 accepts.
- Input during DRAIN:
  - Stimulus: hold in_valid = 1 with a 5th word throughout DRAIN.
  - Required: in_ready = 0 for all 16 drain cycles. The 5th word is accepted as word 0 of the next frame on the first FILL cycle.
- Async reset mid-fill:
  - Stimulus: assert rst after 2 words.
  - Required: out_valid = 0 and in_ready = 1 at once. The next 4 words form a new frame whose output matches the basic case.
- clear mid-drain:
  - Stimulus: pulse clear when out_index = 7.
  - Required: next cycle out_valid = 0, in_ready = 1, no frame_done pulse. A following full frame outputs from index 0.
- Back-to-back frames:
  - Stimulus: two frames with different data (frame 2: Re = 17'h1FF00, i.e. -1.0, at all points), in_valid held high.
  - Required: period of 20 cycles. Two frame_done pulses. Frame 2 outputs all equal 17'h1FF00.
